mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//  Block-transfer initiator that drives the single-port synchronous RAM port
//  (en/memwrite/memread/adr/writedata -> memdata). Copies len words from src
//  to dst.
//  Sits between the processor's control path and data RAM, issuing the
//  read-then-write sequence and honouring the RAM's 1-cycle registered read.
//  The CPU starts it with a 1-cycle pulse and polls busy or waits for done.
// PARAMETERS
//  WIDTH          16  data word width; must match RAM WIDTH
//  RAM_ADDR_BITS  16  address width; also width of len and the word counter
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-high reset
//  start      in   1              1-cycle request; sampled only in IDLE
//  src        in   RAM_ADDR_BITS  first source address, latched on start
//  dst        in   RAM_ADDR_BITS  first destination address, latched on start
//  len        in   RAM_ADDR_BITS  word count, latched on start; 0 = no transfer
//  fill       in   1              fill-mode select, latched on start (see CONFIGURATION)
//  fill_value in   WIDTH          fill word, latched on start
//  busy       out  1              high while in RD/WR/FL states
//  done       out  1              1-cycle pulse when a transfer completes
//  mem_en     out  1              RAM enable
//  mem_write  out  1              RAM write strobe
//  mem_read   out  1              RAM read strobe
//  mem_adr    out  RAM_ADDR_BITS  RAM address
//  mem_wdata  out  WIDTH          RAM write data
//  mem_rdata  in   WIDTH          RAM registered read data; valid cycle after read
// BEHAVIOUR
//  - States: IDLE, RD, WR, FL (fill), DONE. All state and counters are registered.
//    mem_* outputs decode from registered state only. No comb path start->mem_*.
//  - Reset: state=IDLE. Address and count registers = 0. busy=0, done=0.
//    mem_en/mem_write/mem_read=0, mem_adr=0, mem_wdata=0.
//  - IDLE: mem_* all 0. start=1 latches src/dst/len/fill/fill_value.
//    len==0 -> DONE. fill (macro on) -> FL. Otherwise -> RD.
//  - RD: mem_en=1, mem_read=1, mem_write=0, mem_adr=src_ptr -> WR.
//  - WR: mem_en=1, mem_write=1, mem_read=0, mem_adr=dst_ptr, mem_wdata=mem_rdata.
//    Increment src_ptr, dst_ptr; decrement remaining count.
//    Count reaching 0 -> DONE, else -> RD.
//  - FL: mem_en=1, mem_write=1, mem_adr=dst_ptr, mem_wdata=fill_value.
//    Increment dst_ptr, decrement count. Count 0 -> DONE. One word per cycle.
//  - DONE: done=1, busy=0, mem_* all 0 -> IDLE. start ignored in DONE.
//  - Copy latency: start sampled at edge 0. Copy of N words: RD/WR cycles 1..2N.
//    done high in cycle 2N+1. Next start is accepted in cycle 2N+2.
//  - Address arithmetic is modulo 2^RAM_ADDR_BITS. 0xFFFF+1 wraps to 0x0000.
//  - Copy is strictly ascending, word by word. Overlap with dst>src replicates
//    the source pattern. This is defined behaviour, not an error.
//  - start while busy or in DONE: ignored, latched values unchanged.
//  - reset mid-transfer: abort in the same edge and return to reset values.
//    No done pulse. Writes already performed remain in RAM.
//  - mem_read and mem_write are never both 1 in the same cycle.
// CONFIGURATION
//  MEM_COPY_FILL_EN defined: fill=1 at start selects FL. N words take N cycles.
//  Not defined: FL state and fill registers are not built. fill and fill_value
//  are ignored. Every transfer is a copy.
// TESTING
//  1. reset, then idle 5 cycles -> busy=0, done=0, all mem_* = 0.
//  2. RAM[0x10..0x13]={1,2,3,4}; start src=0x10 dst=0x40 len=4
//     -> RAM[0x40..0x43]={1,2,3,4}. done pulse exactly at cycle 9, busy for 8 cycles.
//  3. start len=0 -> no mem_en assertion. done pulse at cycle 1.
//  4. src=0xFFFE dst=0x0100 len=3 -> reads 0xFFFE,0xFFFF,0x0000 (wrap).
//     Writes go to 0x100..0x102.
//  5. Mid-transfer (len=8, cycle 5): pulse start with new args -> ignored.
//     Original copy completes. Then assert reset at cycle 7 of a new
//     len=8 transfer -> state IDLE next cycle, no done, only 3 words written.
//  6. With MEM_COPY_FILL_EN: fill=1, fill_value=0xBEEF, dst=0x20, len=5
//     -> RAM[0x20..0x24]=0xBEEF, done at cycle 6, mem_read never 1.
//     Without the macro: the same stimulus performs a copy from src.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// RAM-side bus of the block-copy engine.
// Master drives the single-port RAM; slave is the RAM.
interface mem_copy_engine_if #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16
);
    logic                     mem_en;
    logic                     mem_write;
    logic                     mem_read;
    logic [RAM_ADDR_BITS-1:0] mem_adr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;

    modport master (
        output mem_en,
        output mem_write,
        output mem_read,
        output mem_adr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_write,
        input  mem_read,
        input  mem_adr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy initiator driving a single-port RAM with 1-cycle registered read.
// Define MEM_COPY_FILL_EN to build the constant-fill (FL) mode.
module mem_copy_engine #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] src,
    input  logic [RAM_ADDR_BITS-1:0] dst,
    input  logic [RAM_ADDR_BITS-1:0] len,
    input  logic                     fill,
    input  logic [WIDTH-1:0]         fill_value,
    output logic                     busy,
    output logic                     done,
    mem_copy_engine_if.master        mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
`ifdef MEM_COPY_FILL_EN
        S_FL   = 3'd4,
`endif
        S_DONE = 3'd3
    } state_e;

    localparam logic [RAM_ADDR_BITS-1:0] ONE = RAM_ADDR_BITS'(1);

    state_e                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] src_q, src_d;
    logic [RAM_ADDR_BITS-1:0] dst_q, dst_d;
    logic [RAM_ADDR_BITS-1:0] cnt_q, cnt_d;

`ifdef MEM_COPY_FILL_EN
    logic [WIDTH-1:0]         fv_q, fv_d;
`else
    logic                     unused_fill;
    assign unused_fill = ^{fill, fill_value};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
`ifdef MEM_COPY_FILL_EN
            fv_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
`ifdef MEM_COPY_FILL_EN
            fv_q    <= fv_d;
`endif
        end
    end

    // Count is checked before decrement: the last word leaves with cnt_q==1.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
`ifdef MEM_COPY_FILL_EN
        fv_d    = fv_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    cnt_d = len;
`ifdef MEM_COPY_FILL_EN
                    fv_d  = fill_value;
`endif
                    if (len == '0) begin
                        state_d = S_DONE;
`ifdef MEM_COPY_FILL_EN
                    end else if (fill) begin
                        state_d = S_FL;
`endif
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                src_d   = src_q + ONE;
                dst_d   = dst_q + ONE;
                cnt_d   = cnt_q - ONE;
                state_d = (cnt_q == ONE) ? S_DONE : S_RD;
            end
`ifdef MEM_COPY_FILL_EN
            S_FL: begin
                dst_d   = dst_q + ONE;
                cnt_d   = cnt_q - ONE;
                state_d = (cnt_q == ONE) ? S_DONE : S_FL;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_en    = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_adr   = '0;
        mem.mem_wdata = '0;
        unique case (state_q)
            S_RD: begin
                busy         = 1'b1;
                mem.mem_en   = 1'b1;
                mem.mem_read = 1'b1;
                mem.mem_adr  = src_q;
            end
            S_WR: begin
                busy          = 1'b1;
                mem.mem_en    = 1'b1;
                mem.mem_write = 1'b1;
                mem.mem_adr   = dst_q;
                mem.mem_wdata = mem.mem_rdata;
            end
`ifdef MEM_COPY_FILL_EN
            S_FL: begin
                busy          = 1'b1;
                mem.mem_en    = 1'b1;
                mem.mem_write = 1'b1;
                mem.mem_adr   = dst_q;
                mem.mem_wdata = fv_q;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural RAM.
// Cycle k is the interval after edge k-1; start is sampled at edge 0.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src, dst, len;
    logic        fill;
    logic [15:0] fill_value;
    logic        busy, done;

    mem_copy_engine_if #(.WIDTH(16), .RAM_ADDR_BITS(16)) mif ();

    mem_copy_engine #(.WIDTH(16), .RAM_ADDR_BITS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill       (fill),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .mem        (mif.master)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:65535];
    logic        pk_we = 1'b0;
    logic [15:0] pk_adr = '0;
    logic [15:0] pk_dat = '0;
    logic [15:0] rdata_q = '0;

    assign mif.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (pk_we) ram[pk_adr] <= pk_dat;
        else if (mif.mem_en && mif.mem_write) ram[mif.mem_adr] <= mif.mem_wdata;
        if (mif.mem_en && mif.mem_read) rdata_q <= ram[mif.mem_adr];
    end

    int n_cmp = 0;
    int n_err = 0;

    int done_cyc, busy_n, wr_n, rd_n, en_n, both_n;
    logic done_after, post_busy, post_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pk_we = 1'b1; pk_adr = a; pk_dat = d;
        @(negedge clk);
        pk_we = 1'b0;
    endtask

    task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       input logic f, input logic [15:0] fv,
                       input int inj, input int rst_c, input int maxc);
        done_cyc = 0; busy_n = 0; wr_n = 0; rd_n = 0; en_n = 0; both_n = 0;
        done_after = 1'bx; post_busy = 1'bx; post_en = 1'bx;
        @(negedge clk);
        src = s; dst = d; len = l; fill = f; fill_value = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            if (busy) busy_n++;
            if (mif.mem_en) en_n++;
            if (mif.mem_write) wr_n++;
            if (mif.mem_read) rd_n++;
            if (mif.mem_read && mif.mem_write) both_n++;
            if (c == rst_c + 1) begin
                post_busy = busy; post_en = mif.mem_en; reset = 1'b0;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            start = 1'b0;
            if (c == inj) begin
                src = 16'h0500; dst = 16'h0600; len = 16'h0002; start = 1'b1;
            end
            if (c == rst_c) reset = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        done_after = done;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        fill = 1'b0; fill_value = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_en", 32'(mif.mem_en), 32'h0);
        chk("idle_wr", 32'(mif.mem_write), 32'h0);
        chk("idle_rd", 32'(mif.mem_read), 32'h0);
        chk("idle_adr", 32'(mif.mem_adr), 32'h0);
        chk("idle_wdata", 32'(mif.mem_wdata), 32'h0);

        poke(16'h0010, 16'h0001); poke(16'h0011, 16'h0002);
        poke(16'h0012, 16'h0003); poke(16'h0013, 16'h0004);
        run(16'h0010, 16'h0040, 16'd4, 1'b0, 16'h0, 0, 0, 50);
        chk("cp4_done_cyc", 32'(done_cyc), 32'd9);
        chk("cp4_busy_n", 32'(busy_n), 32'd8);
        chk("cp4_rd_n", 32'(rd_n), 32'd4);
        chk("cp4_wr_n", 32'(wr_n), 32'd4);
        chk("cp4_both", 32'(both_n), 32'd0);
        chk("cp4_done_pulse", 32'(done_after), 32'h0);
        chk("cp4_ram40", 32'(ram[16'h0040]), 32'h1);
        chk("cp4_ram41", 32'(ram[16'h0041]), 32'h2);
        chk("cp4_ram42", 32'(ram[16'h0042]), 32'h3);
        chk("cp4_ram43", 32'(ram[16'h0043]), 32'h4);
        chk("cp4_ram44", 32'(ram[16'h0044]), 32'h0);

        run(16'h0010, 16'h0080, 16'd0, 1'b0, 16'h0, 0, 0, 20);
        chk("len0_done_cyc", 32'(done_cyc), 32'd1);
        chk("len0_en_n", 32'(en_n), 32'd0);
        chk("len0_busy_n", 32'(busy_n), 32'd0);

        poke(16'hFFFE, 16'h00A1); poke(16'hFFFF, 16'h00A2); poke(16'h0000, 16'h00A3);
        run(16'hFFFE, 16'h0100, 16'd3, 1'b0, 16'h0, 0, 0, 50);
        chk("wrap_done_cyc", 32'(done_cyc), 32'd7);
        chk("wrap_ram100", 32'(ram[16'h0100]), 32'hA1);
        chk("wrap_ram101", 32'(ram[16'h0101]), 32'hA2);
        chk("wrap_ram102", 32'(ram[16'h0102]), 32'hA3);

        for (int k = 0; k < 8; k++) poke(16'(16'h0200 + k), 16'(16'h0011 * (k + 1)));
        run(16'h0200, 16'h0300, 16'd8, 1'b0, 16'h0, 5, 0, 60);
        chk("inj_done_cyc", 32'(done_cyc), 32'd17);
        chk("inj_wr_n", 32'(wr_n), 32'd8);
        chk("inj_ram300", 32'(ram[16'h0300]), 32'h11);
        chk("inj_ram307", 32'(ram[16'h0307]), 32'h88);
        chk("inj_ram600", 32'(ram[16'h0600]), 32'h0);

        run(16'h0200, 16'h0700, 16'd8, 1'b0, 16'h0, 0, 7, 25);
        chk("rst_no_done", 32'(done_cyc), 32'd0);
        chk("rst_wr_n", 32'(wr_n), 32'd3);
        chk("rst_post_busy", 32'(post_busy), 32'h0);
        chk("rst_post_en", 32'(post_en), 32'h0);
        chk("rst_ram702", 32'(ram[16'h0702]), 32'h33);
        chk("rst_ram703", 32'(ram[16'h0703]), 32'h0);

        run(16'h0010, 16'h0020, 16'd5, 1'b1, 16'hBEEF, 0, 0, 50);
`ifdef MEM_COPY_FILL_EN
        chk("fill_done_cyc", 32'(done_cyc), 32'd6);
        chk("fill_rd_n", 32'(rd_n), 32'd0);
        chk("fill_ram20", 32'(ram[16'h0020]), 32'hBEEF);
        chk("fill_ram22", 32'(ram[16'h0022]), 32'hBEEF);
        chk("fill_ram24", 32'(ram[16'h0024]), 32'hBEEF);
`else
        chk("nofill_done_cyc", 32'(done_cyc), 32'd11);
        chk("nofill_rd_n", 32'(rd_n), 32'd5);
        chk("nofill_ram20", 32'(ram[16'h0020]), 32'h1);
        chk("nofill_ram23", 32'(ram[16'h0023]), 32'h4);
        chk("nofill_ram24", 32'(ram[16'h0024]), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
